// File: rtl/control_unit.sv
// Multi-cycle accumulator-machine sequencer: fetch/decode/execute FSM driving register write enables.
// Outputs are Moore-style from current state and ir; fetch+decode takes 4 cycles, STORE 6, LOAD/ALU 8.
// No backpressure: memory read latency is a fixed single cycle; start is honoured only in IDLE.
module control_unit #(
    parameter int ADDR_W = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic        acc_zero,
    input  logic        acc_neg,
    output logic        mar_write,
    output logic        mbr_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        acc_write,
    output logic        mar_sel,
    output logic        pc_sel,
    output logic        acc_sel,
    output logic        mem_write,
    output logic [3:0]  alu_op,
    output logic        halted,
    output logic [3:0]  state,
    output logic [15:0] retired
);

    // State encoding is visible on the debug port, so the values are fixed.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F_ADDR = 4'd1,
        S_F_WAIT = 4'd2,
        S_F_LOAD = 4'd3,
        S_DECODE = 4'd4,
        S_O_ADDR = 4'd5,
        S_O_WAIT = 4'd6,
        S_O_LOAD = 4'd7,
        S_O_EXEC = 4'd8,
        S_ST_WR  = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [3:0] OP_LOAD    = 4'h1;
    localparam logic [3:0] OP_STORE   = 4'h2;
    localparam logic [3:0] OP_ADD     = 4'h3;
    localparam logic [3:0] OP_SUB     = 4'h4;
    localparam logic [3:0] OP_AND     = 4'h5;
    localparam logic [3:0] OP_OR      = 4'h6;
    localparam logic [3:0] OP_HALT    = 4'h7;
    localparam logic [3:0] OP_SKIPZ   = 4'h8;
    localparam logic [3:0] OP_JUMP    = 4'h9;
    localparam logic [3:0] OP_SKIPNEG = 4'hA;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_retired;
    logic [3:0]  w_opcode;
    logic        w_retire;

    logic        w_mar_write;
    logic        w_mbr_write;
    logic        w_ir_write;
    logic        w_pc_write;
    logic        w_acc_write;
    logic        w_mar_sel;
    logic        w_pc_sel;
    logic        w_acc_sel;
    logic        w_mem_write;
    logic [3:0]  w_alu_op;
    logic        w_halted;

    // The operand address only steers the datapath muxes; the sequencer never looks at it.
    logic        w_unused_operand;
    assign w_unused_operand = ^ir[ADDR_W-1:0];

    assign w_opcode = ir[15:12];

    // State register; reset forces IDLE immediately so every enable drops without a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs; every enable defaults low and is raised only where needed.
    always_comb begin
        w_next      = r_state;
        w_mar_write = 1'b0;
        w_mbr_write = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_acc_write = 1'b0;
        w_mar_sel   = 1'b0;
        w_pc_sel    = 1'b0;
        w_acc_sel   = 1'b0;
        w_mem_write = 1'b0;
        w_alu_op    = ALU_ADD;
        w_halted    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_F_ADDR;
                end
            end

            // MAR <- PC to address the next instruction.
            S_F_ADDR: begin
                w_mar_write = 1'b1;
                w_mar_sel   = 1'b0;
                w_next      = S_F_WAIT;
            end

            // Memory read in flight; use the spare cycle to advance PC.
            S_F_WAIT: begin
                w_pc_write = 1'b1;
                w_pc_sel   = 1'b0;
                w_next     = S_F_LOAD;
            end

            S_F_LOAD: begin
                w_ir_write = 1'b1;
                w_next     = S_DECODE;
            end

            // Control-flow instructions complete here by adjusting PC directly.
            S_DECODE: begin
                case (w_opcode)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STORE: begin
                        w_next = S_O_ADDR;
                    end
                    OP_HALT: begin
                        w_next = S_HALT;
                    end
                    OP_JUMP: begin
                        w_pc_write = 1'b1;
                        w_pc_sel   = 1'b1;
                        w_next     = S_F_ADDR;
                    end
                    OP_SKIPZ: begin
                        w_pc_write = acc_zero;
                        w_next     = S_F_ADDR;
                    end
                    OP_SKIPNEG: begin
                        w_pc_write = acc_neg;
                        w_next     = S_F_ADDR;
                    end
                    default: begin
                        w_next = S_F_ADDR;
                    end
                endcase
            end

            // MAR <- operand address; stores skip the read path entirely.
            S_O_ADDR: begin
                w_mar_write = 1'b1;
                w_mar_sel   = 1'b1;
                if (w_opcode == OP_STORE) begin
                    w_next = S_ST_WR;
                end else begin
                    w_next = S_O_WAIT;
                end
            end

            S_O_WAIT: begin
                w_next = S_O_LOAD;
            end

            S_O_LOAD: begin
                w_mbr_write = 1'b1;
                w_next      = S_O_EXEC;
            end

            // ACC takes MBR for LOAD, otherwise the ALU result for the selected operation.
            S_O_EXEC: begin
                w_acc_write = 1'b1;
                case (w_opcode)
                    OP_LOAD: w_acc_sel = 1'b1;
                    OP_SUB:  w_alu_op  = ALU_SUB;
                    OP_AND:  w_alu_op  = ALU_AND;
                    OP_OR:   w_alu_op  = ALU_OR;
                    default: w_alu_op  = ALU_ADD;
                endcase
                w_next = S_F_ADDR;
            end

            S_ST_WR: begin
                w_mem_write = 1'b1;
                w_next      = S_F_ADDR;
            end

            // Terminal until reset; start is deliberately ignored.
            S_HALT: begin
                w_halted = 1'b1;
                w_next   = S_HALT;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // An instruction retires on its last active cycle; HALT retires as it is entered.
    assign w_retire = ((r_state == S_DECODE) &&
                       ((w_next == S_F_ADDR) || (w_next == S_HALT))) ||
                      (r_state == S_O_EXEC) ||
                      (r_state == S_ST_WR);

    // Retired-instruction counter, free-running modulo 2^16.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= 16'd0;
        end else if (w_retire) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign mar_write = w_mar_write;
    assign mbr_write = w_mbr_write;
    assign ir_write  = w_ir_write;
    assign pc_write  = w_pc_write;
    assign acc_write = w_acc_write;
    assign mar_sel   = w_mar_sel;
    assign pc_sel    = w_pc_sel;
    assign acc_sel   = w_acc_sel;
    assign mem_write = w_mem_write;
    assign alu_op    = w_alu_op;
    assign halted    = w_halted;
    assign state     = r_state;
    assign retired   = r_retired;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected cycle traces queued, monitor compares each cycle.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// No backpressure: every queued cycle record is consumed by exactly one falling edge.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] ir;
    logic        acc_zero;
    logic        acc_neg;
    logic        mar_write, mbr_write, ir_write, pc_write, acc_write;
    logic        mar_sel, pc_sel, acc_sel, mem_write;
    logic [3:0]  alu_op;
    logic        halted;
    logic [3:0]  state;
    logic [15:0] retired;

    always #5 clock = ~clock;

    control_unit #(.ADDR_W(12)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .ir        (ir),
        .acc_zero  (acc_zero),
        .acc_neg   (acc_neg),
        .mar_write (mar_write),
        .mbr_write (mbr_write),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .acc_write (acc_write),
        .mar_sel   (mar_sel),
        .pc_sel    (pc_sel),
        .acc_sel   (acc_sel),
        .mem_write (mem_write),
        .alu_op    (alu_op),
        .halted    (halted),
        .state     (state),
        .retired   (retired)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [8:0]  en;   // mar_w mbr_w ir_w pc_w acc_w mar_s pc_s acc_s mem_w
        logic [3:0]  alu;
        logic        hlt;
        logic [15:0] ret;
    } obs_t;

    localparam logic [8:0] MARW = 9'h100;
    localparam logic [8:0] MBRW = 9'h080;
    localparam logic [8:0] IRW  = 9'h040;
    localparam logic [8:0] PCW  = 9'h020;
    localparam logic [8:0] ACCW = 9'h010;
    localparam logic [8:0] MARS = 9'h008;
    localparam logic [8:0] PCS  = 9'h004;
    localparam logic [8:0] ACCS = 9'h002;
    localparam logic [8:0] MEMW = 9'h001;

    obs_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_ret;

    // Directed instructions: {ir, acc_zero, acc_neg}
    logic [17:0] dir [13] = '{
        {16'h1005, 2'b00}, {16'h3010, 2'b00}, {16'h4010, 2'b00}, {16'h2020, 2'b00},
        {16'h8000, 2'b10}, {16'h8000, 2'b00}, {16'h9123, 2'b00}, {16'hA000, 2'b01},
        {16'hA000, 2'b00}, {16'h5010, 2'b00}, {16'h6010, 2'b00}, {16'hF000, 2'b11},
        {16'h0000, 2'b00}
    };

    function automatic obs_t rec(input logic [3:0] st, input logic [8:0] en,
                                 input logic [3:0] alu, input logic hlt, input logic [15:0] ret);
        obs_t o;
        o.st = st; o.en = en; o.alu = alu; o.hlt = hlt; o.ret = ret;
        return o;
    endfunction

    function automatic obs_t sample();
        return rec(state, {mar_write, mbr_write, ir_write, pc_write, acc_write,
                           mar_sel, pc_sel, acc_sel, mem_write}, alu_op, halted, retired);
    endfunction

    task automatic check(input string nm, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got st=%0d en=%b alu=%b hlt=%b ret=%h, want st=%0d en=%b alu=%b hlt=%b ret=%h",
                     nm, act.st, act.en, act.alu, act.hlt, act.ret,
                     exp.st, exp.en, exp.alu, exp.hlt, exp.ret);
        end
    endtask

    // Monitor: one expected record per cycle while the queue holds any.
    initial begin
        obs_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("cycle_st%0d", e.st), sample(), e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] alu_of(input logic [3:0] op);
        case (op)
            4'h4:    return 4'b0001;
            4'h5:    return 4'b1000;
            4'h6:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic push_fetch(input logic [8:0] dec_en);
        sb.push_back(rec(4'd1, MARW, 4'd0, 1'b0, m_ret));
        sb.push_back(rec(4'd2, PCW,  4'd0, 1'b0, m_ret));
        sb.push_back(rec(4'd3, IRW,  4'd0, 1'b0, m_ret));
        sb.push_back(rec(4'd4, dec_en, 4'd0, 1'b0, m_ret));
    endtask

    task automatic idle_cycle();
        sb.push_back(rec(4'd0, 9'd0, 4'd0, 1'b0, m_ret));
        step();
    endtask

    task automatic do_start();
        sb.push_back(rec(4'd0, 9'd0, 4'd0, 1'b0, m_ret));
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called with the DUT in F_ADDR; queues the whole instruction, then runs it.
    task automatic issue(input logic [15:0] ins, input logic az, input logic an);
        logic [3:0] op;
        logic [8:0] den;
        int         n;
        ir = ins; acc_zero = az; acc_neg = an;
        op = ins[15:12];
        den = 9'd0;
        if (op == 4'h9)              den = PCW | PCS;
        else if (op == 4'h8 && az)   den = PCW;
        else if (op == 4'hA && an)   den = PCW;
        push_fetch(den);
        n = 4;
        case (op)
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6: begin
                sb.push_back(rec(4'd5, MARW | MARS, 4'd0, 1'b0, m_ret));
                sb.push_back(rec(4'd6, 9'd0, 4'd0, 1'b0, m_ret));
                sb.push_back(rec(4'd7, MBRW, 4'd0, 1'b0, m_ret));
                sb.push_back(rec(4'd8, ACCW | ((op == 4'h1) ? ACCS : 9'd0), alu_of(op), 1'b0, m_ret));
                n = 8;
            end
            4'h2: begin
                sb.push_back(rec(4'd5, MARW | MARS, 4'd0, 1'b0, m_ret));
                sb.push_back(rec(4'd9, MEMW, 4'd0, 1'b0, m_ret));
                n = 6;
            end
            default: ;
        endcase
        m_ret = m_ret + 16'd1;
        repeat (n) step();
    endtask

    // HALT: fetch/decode at the old count, then halted with count+1 while start wiggles.
    task automatic do_halt(input int hold);
        ir = 16'h7000;
        push_fetch(9'd0);
        m_ret = m_ret + 16'd1;
        for (int k = 0; k < hold; k++) sb.push_back(rec(4'd10, 9'd0, 4'd0, 1'b1, m_ret));
        repeat (4) step();
        for (int k = 0; k < hold; k++) begin
            start = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0;
    endtask

    // STORE interrupted by reset while in ST_WR, between clock edges.
    task automatic store_reset();
        ir = 16'h2020;
        push_fetch(9'd0);
        sb.push_back(rec(4'd5, MARW | MARS, 4'd0, 1'b0, m_ret));
        sb.push_back(rec(4'd9, MEMW, 4'd0, 1'b0, m_ret));
        repeat (5) step();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        m_ret = 16'd0;
        check("rst_in_stwr", sample(), rec(4'd0, 9'd0, 4'd0, 1'b0, 16'd0));
        step();
        check("rst_stwr_hold", sample(), rec(4'd0, 9'd0, 4'd0, 1'b0, 16'd0));
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] ins;
        reset_n = 1'b0; start = 1'b0; ir = 16'h0000; acc_zero = 1'b0; acc_neg = 1'b0;
        m_ret = 16'd0;

        #3;
        check("rst_async", sample(), rec(4'd0, 9'd0, 4'd0, 1'b0, 16'd0));
        start = 1'b1;
        repeat (2) step();
        check("rst_hold_start", sample(), rec(4'd0, 9'd0, 4'd0, 1'b0, 16'd0));
        start = 1'b0;
        reset_n = 1'b1;
        repeat (3) idle_cycle();
        do_start();

        for (int i = 0; i < 13; i++) issue(dir[i][17:2], dir[i][1], dir[i][0]);

        for (int i = 0; i < 40; i++) begin
            ins = 16'($urandom);
            if (ins[15:12] == 4'h7) ins[15:12] = 4'h0;
            issue(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        do_halt(20);

        // Reset out of HALT without a clock edge.
        reset_n = 1'b0;
        #1;
        m_ret = 16'd0;
        check("rst_from_halt", sample(), rec(4'd0, 9'd0, 4'd0, 1'b0, 16'd0));
        repeat (2) step();
        reset_n = 1'b1;
        repeat (2) idle_cycle();
        do_start();
        issue(16'h1ABC, 1'b0, 1'b0);
        store_reset();
        repeat (2) idle_cycle();

        // Preload the counter just below wrap, then retire two instructions.
        force dut.r_retired = 16'hFFFF;
        #1;
        release dut.r_retired;
        m_ret = 16'hFFFF;
        do_start();
        issue(16'h0000, 1'b0, 1'b0);
        issue(16'h9001, 1'b0, 1'b0);
        issue(16'h2020, 1'b0, 1'b0);
        do_halt(5);

        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d records pending, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: ADDR_W, default 12, width of operand address field IR[ADDR_W-1:0].
REQ-002 clock  input  1  system clock, all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level; in IDLE, begins fetch at current PC.
REQ-005 ir  input  16  instruction register contents; opcode = ir[15:12].
REQ-006 acc_zero  input  1  accumulator == 0.
REQ-007 acc_neg  input  1  accumulator bit 15.
REQ-008 mar_write, mbr_write, ir_write, pc_write, acc_write  output  1 each  register write enables, sampled by registers on the same edge.
REQ-009 mar_sel  output  1  0 = MAR loads PC, 1 = MAR loads ir[ADDR_W-1:0].
REQ-010 pc_sel  output  1  0 = PC loads PC+1, 1 = PC loads ir[ADDR_W-1:0].
REQ-011 acc_sel  output  1  0 = ACC loads ALU result, 1 = ACC loads MBR.
REQ-012 mem_write  output  1  main memory write enable (data = ACC, address = MAR).
REQ-013 alu_op  output  4  ALU operation code.
REQ-014 halted  output  1  high while in HALT.
REQ-015 state  output  4  current state encoding, debug.
REQ-016 retired  output  16  count of completed instructions.

Function
REQ-017 States/encoding: IDLE 0, F_ADDR 1, F_WAIT 2, F_LOAD 3, DECODE 4, O_ADDR 5, O_WAIT 6, O_LOAD 7, O_EXEC 8, ST_WR 9, HALT 10; unused encodings go to IDLE next cycle.
REQ-018 Outputs Moore-style from state and ir; every enable/select not listed for a state is 0.
REQ-019 IDLE: start=1 -> F_ADDR, else stay.
REQ-020 F_ADDR: mar_write=1, mar_sel=0 -> F_WAIT.
REQ-021 F_WAIT: pc_write=1, pc_sel=0 (memory read latency 1 cycle) -> F_LOAD.
REQ-022 F_LOAD: ir_write=1 -> DECODE.
REQ-023 DECODE by opcode: 1 LOAD, 3 ADD, 4 SUB, 5 AND, 6 OR -> O_ADDR; 2 STORE -> O_ADDR; 7 HALT -> HALT; 8 SKIPZ, A SKIPNEG, 9 JUMP, all other opcodes (NOP) -> F_ADDR.
REQ-024 DECODE JUMP: pc_write=1, pc_sel=1; SKIPZ: pc_write=1, pc_sel=0 iff acc_zero; SKIPNEG: same iff acc_neg.
REQ-025 O_ADDR: mar_write=1, mar_sel=1 -> ST_WR if STORE, else O_WAIT.
REQ-026 O_WAIT -> O_LOAD; O_LOAD: mbr_write=1 -> O_EXEC.
REQ-027 O_EXEC: acc_write=1; LOAD acc_sel=1; ADD alu_op 0000, SUB 0001, AND 1000, OR 1001, acc_sel=0 -> F_ADDR.
REQ-028 alu_op = 0000 in all states other than O_EXEC.
REQ-029 ST_WR: mem_write=1 -> F_ADDR.
REQ-030 HALT: halted=1, all enables 0; stays until reset_n low; start ignored.
REQ-031 retired increments by 1 on leaving DECODE to F_ADDR, on leaving O_EXEC, on leaving ST_WR, and on entering HALT; wraps 0xFFFF -> 0x0000.
REQ-032 Cycle counts from F_ADDR: JUMP/SKIP/NOP 4, STORE 6, LOAD/ALU ops 8, HALT 4 to halted=1.
REQ-033 start is not re-sampled after leaving IDLE; execution runs until HALT.

Reset
REQ-034 reset_n low: immediately state=IDLE, retired=0, halted=0, all enables/selects/mem_write 0, alu_op 0000, independent of clock.
REQ-035 reset_n asserted mid-instruction (including ST_WR) deasserts mem_write and all enables within the same cycle; no partial instruction resumes.
REQ-036 After reset_n rises, block stays in IDLE until start=1 on a rising edge.

Verification
REQ-037 Reset, start=1 one cycle -> state 1,2,3,4 on successive edges; mar_write in 1, pc_write in 2, ir_write in 3.
REQ-038 ir=0x1005 (LOAD) -> states 4,5,6,7,8,1; mar_sel=1 in 5, mbr_write in 7, acc_write with acc_sel=1 in 8; retired +1.
REQ-039 ir=0x3010 (ADD) and 0x4010 (SUB) -> alu_op 0000 / 0001 with acc_write only in O_EXEC; ir=0x2020 (STORE) -> mem_write exactly one cycle in state 9.
REQ-040 ir=0x8000 with acc_zero=1 -> pc_write=1, pc_sel=0 in DECODE; with acc_zero=0 -> pc_write=0; ir=0x9123 -> pc_write=1, pc_sel=1.
REQ-041 ir=0x7000 -> halted=1, state=10 held for 20 cycles with start toggling; retired unchanged afterwards.
REQ-042 reset_n low during ST_WR between edges -> mem_write=0, state=0, retired=0 without a clock edge; 0xFFFF retired wraps to 0 on next completion.
